// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment pair receiver.
// Glyphs are active-low, bit6 = segment a ... bit0 = segment g.
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;
    localparam int DATA_W  = 6;
    localparam int SUM_W   = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b0000100;

    typedef enum logic [1:0] {
        S_TENS,
        S_UNITS,
        S_OUT
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_GLYPH = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

endpackage

// File: rtl/seg7_pair_to_bin_if.sv
// Glyph input stream, binary output stream and error strobe of the pair receiver.
// The slave side is the receiver; the master side is its environment.
interface seg7_pair_to_bin_if;
    import seg7_pkg::*;

    logic [SEG_W-1:0]  seg_code;
    logic              seg_valid;
    logic              seg_ready;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready;
    logic              err_valid;
    logic [1:0]        err_code;

    modport slave (
        input  seg_code,
        input  seg_valid,
        output seg_ready,
        output data,
        output data_valid,
        input  data_ready,
        output err_valid,
        output err_code
    );

    modport master (
        output seg_code,
        output seg_valid,
        input  seg_ready,
        input  data,
        input  data_valid,
        output data_ready,
        input  err_valid,
        input  err_code
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational active-low seven-segment glyph to decimal digit decoder.
// Any pattern outside the ten digit glyphs yields ok = 0 and digit = 0.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]   seg_code,
    output logic [DIGIT_W-1:0] digit,
    output logic               ok
);

    always_comb begin
        digit = '0;
        ok    = 1'b1;
        case (seg_code)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: ok    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_pair_to_bin.sv
// Receives a tens glyph then a units glyph and emits their 6-bit binary value.
// Bad glyphs, results above 63 and an idle gap after the tens digit raise err_valid.
module seg7_pair_to_bin
    import seg7_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    seg7_pair_to_bin_if.slave bus
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    // tens*10 + units built from shifts; 9*10+9 = 99 fits in 7 bits.
    function automatic logic [SUM_W-1:0] mul_add(input logic [DIGIT_W-1:0] tens,
                                                 input logic [DIGIT_W-1:0] units);
        logic [SUM_W-1:0] t;
        t = {{(SUM_W-DIGIT_W){1'b0}}, tens};
        return (t << 3) + (t << 1) + {{(SUM_W-DIGIT_W){1'b0}}, units};
    endfunction

    function automatic logic fits_data(input logic [SUM_W-1:0] v);
        return v <= SUM_W'((1 << DATA_W) - 1);
    endfunction

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [DIGIT_W-1:0]  tens_q, tens_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;

    logic [DIGIT_W-1:0]  dec_digit;
    logic                dec_ok;
    logic                seg_ready;
    logic                accept;
    logic [SUM_W-1:0]    sum;

    seg7_glyph_decode u_dec (
        .seg_code (bus.seg_code),
        .digit    (dec_digit),
        .ok       (dec_ok)
    );

    assign seg_ready = (state_q != S_OUT) && !rst;
    assign accept    = bus.seg_valid && seg_ready;
    assign sum       = mul_add(tens_q, dec_digit);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tens_d  = tens_q;
        data_d  = data_q;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        case (state_q)
            S_TENS: begin
                if (accept) begin
                    if (dec_ok) begin
                        tens_d  = dec_digit;
                        timer_d = '0;
                        state_d = S_UNITS;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_GLYPH;
                    end
                end
            end
            S_UNITS: begin
                // An accept in the final timer cycle takes priority over the timeout.
                if (accept) begin
                    state_d = S_TENS;
                    if (!dec_ok) begin
                        err_d  = 1'b1;
                        code_d = ERR_GLYPH;
                    end else if (fits_data(sum)) begin
                        data_d  = sum[DATA_W-1:0];
                        state_d = S_OUT;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_OVF;
                    end
                end else if (timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                    state_d = S_TENS;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_OUT: begin
                if (bus.data_ready) begin
                    state_d = S_TENS;
                end
            end
            default: state_d = S_TENS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_TENS;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    // The stored tens digit is only read in S_UNITS, after it has been written.
    always_ff @(posedge clk) begin
        tens_q <= tens_d;
    end

    assign bus.seg_ready  = seg_ready;
    assign bus.data       = data_q;
    assign bus.data_valid = (state_q == S_OUT);
    assign bus.err_valid  = err_q;
    assign bus.err_code   = code_q;

endmodule

// File: tb/tb_seg7_pair_to_bin.sv
// Directed bench for seg7_pair_to_bin: a vector table of glyph pairs plus
// hand-written timeout, back-pressure and mid-operation reset sequences.
module tb_seg7_pair_to_bin;

    typedef struct {
        string      name;
        logic [6:0] tens;
        logic [6:0] units;
        logic       tens_bad;
        logic [1:0] exp_err;
        logic [5:0] exp_data;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seg7_pair_to_bin_if bus ();

    seg7_pair_to_bin #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entry/exit: 1 time unit after a rising edge, receiver idle in S_TENS, data_ready=1.
    task automatic run_vec(input vec_t v);
        bus.seg_code  = v.tens;
        bus.seg_valid = 1'b1;
        chk({v.name, " seg_ready tens"}, 32'(bus.seg_ready), 32'd1);
        step();
        if (v.tens_bad) begin
            bus.seg_valid = 1'b0;
            chk({v.name, " err_valid"}, 32'(bus.err_valid), 32'd1);
            chk({v.name, " err_code"}, 32'(bus.err_code), 32'(v.exp_err));
            chk({v.name, " seg_ready after err"}, 32'(bus.seg_ready), 32'd1);
            step();
            chk({v.name, " err_valid clear"}, 32'(bus.err_valid), 32'd0);
            chk({v.name, " err_code clear"}, 32'(bus.err_code), 32'd0);
            return;
        end
        chk({v.name, " err after tens"}, 32'(bus.err_valid), 32'd0);
        bus.seg_code = v.units;
        step();
        bus.seg_valid = 1'b0;
        if (v.exp_err != 2'b00) begin
            chk({v.name, " err_valid"}, 32'(bus.err_valid), 32'd1);
            chk({v.name, " err_code"}, 32'(bus.err_code), 32'(v.exp_err));
            chk({v.name, " no data_valid"}, 32'(bus.data_valid), 32'd0);
        end else begin
            chk({v.name, " data_valid"}, 32'(bus.data_valid), 32'd1);
            chk({v.name, " data"}, 32'(bus.data), 32'(v.exp_data));
            chk({v.name, " no err"}, 32'(bus.err_valid), 32'd0);
            chk({v.name, " seg_ready low in out"}, 32'(bus.seg_ready), 32'd0);
        end
        step();
        chk({v.name, " data_valid drop"}, 32'(bus.data_valid), 32'd0);
        chk({v.name, " err_valid drop"}, 32'(bus.err_valid), 32'd0);
        chk({v.name, " err_code drop"}, 32'(bus.err_code), 32'd0);
        chk({v.name, " seg_ready back"}, 32'(bus.seg_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[12];
        vecs[0]  = '{name:"v23",      tens:7'b0010010, units:7'b0000110, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd23};
        vecs[1]  = '{name:"v55",      tens:7'b0100100, units:7'b0100100, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd55};
        vecs[2]  = '{name:"v11",      tens:7'b1001111, units:7'b1001111, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd11};
        vecs[3]  = '{name:"ovf64",    tens:7'b0100000, units:7'b1001100, tens_bad:1'b0, exp_err:2'b10, exp_data:6'd0};
        vecs[4]  = '{name:"v03",      tens:7'b0000001, units:7'b0000110, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd3};
        vecs[5]  = '{name:"badtens",  tens:7'b1111111, units:7'b0000000, tens_bad:1'b1, exp_err:2'b01, exp_data:6'd0};
        vecs[6]  = '{name:"badunits", tens:7'b0000110, units:7'b0110000, tens_bad:1'b0, exp_err:2'b01, exp_data:6'd0};
        vecs[7]  = '{name:"v63",      tens:7'b0100000, units:7'b0000110, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd63};
        vecs[8]  = '{name:"v00",      tens:7'b0000001, units:7'b0000001, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd0};
        vecs[9]  = '{name:"ovf99",    tens:7'b0000100, units:7'b0000100, tens_bad:1'b0, exp_err:2'b10, exp_data:6'd0};
        vecs[10] = '{name:"v48",      tens:7'b1001100, units:7'b0000000, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd48};
        vecs[11] = '{name:"v57",      tens:7'b0100100, units:7'b0001111, tens_bad:1'b0, exp_err:2'b00, exp_data:6'd57};

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.seg_code   = 7'b1111111;
        bus.seg_valid  = 1'b0;
        bus.data_ready = 1'b1;

        step();
        chk("reset seg_ready", 32'(bus.seg_ready), 32'd0);
        chk("reset data_valid", 32'(bus.data_valid), 32'd0);
        chk("reset data", 32'(bus.data), 32'd0);
        chk("reset err_valid", 32'(bus.err_valid), 32'd0);
        chk("reset err_code", 32'(bus.err_code), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post reset seg_ready", 32'(bus.seg_ready), 32'd1);
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // A bad tens glyph must not start the inter-digit timer.
        bus.seg_code  = 7'b1111111;
        bus.seg_valid = 1'b1;
        step();
        bus.seg_valid = 1'b0;
        chk("bad tens err", 32'(bus.err_code), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no timer after bad tens", 32'(bus.err_valid), 32'd0);
        end

        // Timeout: tens accepted, then four idle cycles.
        bus.seg_code  = 7'b0000110;
        bus.seg_valid = 1'b1;
        step();
        bus.seg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tmo idle no err", 32'(bus.err_valid), 32'd0);
        end
        step();
        chk("tmo err_valid", 32'(bus.err_valid), 32'd1);
        chk("tmo err_code", 32'(bus.err_code), 32'd3);
        chk("tmo no data_valid", 32'(bus.data_valid), 32'd0);
        step();
        chk("tmo err clear", 32'(bus.err_valid), 32'd0);
        chk("tmo code clear", 32'(bus.err_code), 32'd0);

        // Units arriving on the fourth idle cycle beats the timeout: 3,1 -> 31.
        bus.seg_code  = 7'b0000110;
        bus.seg_valid = 1'b1;
        step();
        bus.seg_valid = 1'b0;
        step();
        step();
        step();
        bus.seg_code  = 7'b1001111;
        bus.seg_valid = 1'b1;
        step();
        bus.seg_valid = 1'b0;
        chk("late units no err", 32'(bus.err_valid), 32'd0);
        chk("late units data_valid", 32'(bus.data_valid), 32'd1);
        chk("late units data", 32'(bus.data), 32'd31);
        step();
        chk("late units drop", 32'(bus.data_valid), 32'd0);

        // Back-pressure: 4,6 -> 46 held while data_ready is low.
        bus.data_ready = 1'b0;
        bus.seg_code   = 7'b1001100;
        bus.seg_valid  = 1'b1;
        step();
        bus.seg_code = 7'b0100000;
        step();
        bus.seg_code = 7'b1111111;
        for (int i = 0; i < 5; i++) begin
            chk("stall data_valid", 32'(bus.data_valid), 32'd1);
            chk("stall data", 32'(bus.data), 32'd46);
            chk("stall seg_ready", 32'(bus.seg_ready), 32'd0);
            chk("stall no err", 32'(bus.err_valid), 32'd0);
            step();
        end
        bus.seg_valid  = 1'b0;
        bus.data_ready = 1'b1;
        chk("release data_valid", 32'(bus.data_valid), 32'd1);
        step();
        chk("released data_valid", 32'(bus.data_valid), 32'd0);
        chk("released seg_ready", 32'(bus.seg_ready), 32'd1);
        chk("released no err", 32'(bus.err_valid), 32'd0);

        // Reset after a tens accept: partial digit dropped, no error reported.
        bus.seg_code  = 7'b0000110;
        bus.seg_valid = 1'b1;
        step();
        bus.seg_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst seg_ready", 32'(bus.seg_ready), 32'd0);
        chk("midrst data", 32'(bus.data), 32'd0);
        chk("midrst data_valid", 32'(bus.data_valid), 32'd0);
        chk("midrst err_valid", 32'(bus.err_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("after midrst no err", 32'(bus.err_valid), 32'd0);
        chk("after midrst err_code", 32'(bus.err_code), 32'd0);
        run_vec(vecs[0]);
        run_vec(vecs[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_pair_to_bin.md
# seg7_pair_to_bin

Receives two active-low seven-segment glyphs, tens first then units, over a valid/ready stream. Converts them to a 6-bit binary value (0-63) and presents it on a valid/ready output. Invalid glyphs, overflow and inter-digit timeout are reported on a one-cycle error strobe. This is the receive-side inverse of the team's 6-bit-to-dual-7-segment display encoder; it sits between a glyph source (panel scanner or link) and binary datapath logic.

## Interface
- `TIMEOUT`, default 1000: max idle cycles allowed between tens accept and units accept; must be ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `seg_code`  in  7  glyph, bit6=a … bit0=g, active-low (0 = segment lit).
- `seg_valid`  in  1  `seg_code` valid.
- `seg_ready`  out  1  block can accept a glyph.
- `data`  out  6  decoded binary value.
- `data_valid`  out  1  `data` valid.
- `data_ready`  in  1  consumer accepts `data`.
- `err_valid`  out  1  one-cycle error strobe.
- `err_code`  out  2  01 bad glyph, 10 overflow (>63), 11 timeout; 00 otherwise.

## Operation
- Glyph table, abcdefg active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other code is a bad glyph.
- Accept occurs when `seg_valid && seg_ready` at a rising edge.
- FSM states:
  - S_TENS: wait for the tens glyph.
    - Good glyph: store digit, clear timer, go to S_UNITS.
    - Bad glyph: error 01, stay in S_TENS.
  - S_UNITS: wait for the units glyph.
    - Good glyph: compute tens*10+units in 7 bits.
      - If ≤ 63: load `data`, go to S_OUT.
      - Else: error 10, go to S_TENS.
    - Bad glyph: error 01, go to S_TENS.
    - No accept: timer increments.
    - Timer == TIMEOUT-1 with no accept that cycle: error 11, go to S_TENS.
  - S_OUT: `data_valid`=1 and `data` held stable; `data_ready`=1 returns to S_TENS.
- `seg_ready` = (state != S_OUT) && !rst.
- Errors always discard any stored tens digit.

## Timing
- Reset values: state S_TENS, `data`=0, `data_valid`=0, `err_valid`=0, `err_code`=00, timer=0, `seg_ready`=0 while `rst` is high.
- Latency: `data_valid` rises 1 cycle after the units accept. `err_valid`/`err_code` are registered and appear 1 cycle after the offending accept or timeout cycle.
- `err_code` returns to 00 whenever `err_valid`=0.
- Output handshake completes on `data_valid && data_ready`. `data_valid` drops the next cycle and `seg_ready` rises the same cycle. Minimum period is 3 cycles per value.
- Back-to-back input: a tens glyph may be accepted in the cycle immediately after S_OUT exits, or after an error.
- Simultaneous events:
  - An accept in the timeout cycle wins; no timeout error.
  - A bad glyph in S_TENS never starts the timer.
- `rst` mid-operation: immediate return to reset values. A partial digit is discarded and no error is reported.

## Structure
- Package `seg7_pkg`:
  - glyph constants SEG_0..SEG_9 (7-bit);
  - state enum {S_TENS, S_UNITS, S_OUT};
  - err code constants ERR_NONE/ERR_GLYPH/ERR_OVF/ERR_TMO.
- Sub-module `seg7_glyph_decode`: combinational, 7-bit glyph → 4-bit digit plus `ok` flag. It is shared with future panel-readback logic.
- Top level contains the FSM, a $clog2(TIMEOUT)-bit timer, and the multiply-add (tens*8 + tens*2 + units).

## Test plan
- Glyph 0010010 then 0000110 with `data_ready`=1 → `data`=23 (010111), `data_valid` for 1 cycle, no error.
- Glyph 0100100 twice → 55 (110111). Then 1001111, 1001111 → 11 (001011).
- Glyph 0100000 then 1001100 (64) → `err_valid`=1, `err_code`=10, no `data_valid`. Next pair 0000001, 0000110 → 3.
- Tens 1111111 → error 01 with state still S_TENS. Tens 0000110 then units 0110000 → error 01 and tens discarded.
- With TIMEOUT=4: tens accepted, then no glyph for 4 cycles → error 11. Repeat with units arriving on the 4th idle cycle → no error, valid data.
- Pair 1001100, 0100000 (46) with `data_ready`=0 for 5 cycles → `data`=101110 stable, `seg_ready`=0 throughout. Assert `rst` after a tens accept → all outputs reset values, and the next full pair decodes correctly.
